// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: operand-forwarding select codes and control-word layout.
package pipeline_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t SEL_RF  = 2'b00;
    localparam fwd_sel_t SEL_EX  = 2'b01;
    localparam fwd_sel_t SEL_MEM = 2'b10;
    localparam fwd_sel_t SEL_WB  = 2'b11;

    localparam int LD_BIT = 0;
    localparam int RF_BIT = 1;

    localparam logic [7:0] CTRL_NOP = 8'h00;

    // True when any operand of the instruction comes from a later pipeline stage.
    function automatic logic uses_fwd(input fwd_sel_t isa, input fwd_sel_t isb, input fwd_sel_t isd);
        return (isa != SEL_RF) || (isb != SEL_RF) || (isd != SEL_RF);
    endfunction

endpackage

// File: rtl/fwd_mux4.sv
// Four-way operand select between register file and the EX/MEM/WB bypass paths.
module fwd_mux4
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] rf_val,
    input  logic [DATA_W-1:0] ex_val,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [DATA_W-1:0] wb_val,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = rf_val;
        case (sel)
            SEL_RF:  y = rf_val;
            SEL_EX:  y = ex_val;
            SEL_MEM: y = mem_val;
            SEL_WB:  y = wb_val;
            default: y = rf_val;
        endcase
    end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with operand forwarding, bubble/flush insertion and debug event counters.
module id_ex_forward_stage #(
    parameter int DATA_W = 32,
    parameter int CW_W   = 8,
    parameter int LD_BIT = pipeline_pkg::LD_BIT,
    parameter int RF_BIT = pipeline_pkg::RF_BIT,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] PA,
    input  logic [DATA_W-1:0] PB,
    input  logic [DATA_W-1:0] PD,
    input  logic [DATA_W-1:0] EX_RESULT,
    input  logic [DATA_W-1:0] MEM_RESULT,
    input  logic [DATA_W-1:0] WB_RESULT,
    input  logic [1:0]        ISA,
    input  logic [1:0]        ISB,
    input  logic [1:0]        ISD,
    input  logic              C_Unit_MUX,
    input  logic              FLUSH,
    input  logic [CW_W-1:0]   CTRL_ID,
    input  logic [3:0]        RW_ID,
    output logic [DATA_W-1:0] A_EX,
    output logic [DATA_W-1:0] B_EX,
    output logic [DATA_W-1:0] D_EX,
    output logic [CW_W-1:0]   CTRL_EX,
    output logic [3:0]        RW_EX,
    output logic              VALID_EX,
    output logic              enable_LD_EX,
    output logic              enable_RF_EX,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FWD_CNT
);

    logic [DATA_W-1:0] a_mux;
    logic [DATA_W-1:0] b_mux;
    logic [DATA_W-1:0] d_mux;

    fwd_mux4 #(.DATA_W(DATA_W)) u_mux_a (
        .sel(ISA), .rf_val(PA), .ex_val(EX_RESULT), .mem_val(MEM_RESULT), .wb_val(WB_RESULT), .y(a_mux)
    );
    fwd_mux4 #(.DATA_W(DATA_W)) u_mux_b (
        .sel(ISB), .rf_val(PB), .ex_val(EX_RESULT), .mem_val(MEM_RESULT), .wb_val(WB_RESULT), .y(b_mux)
    );
    fwd_mux4 #(.DATA_W(DATA_W)) u_mux_d (
        .sel(ISD), .rf_val(PD), .ex_val(EX_RESULT), .mem_val(MEM_RESULT), .wb_val(WB_RESULT), .y(d_mux)
    );

    // Operand registers hold through bubbles and flushes; only VALID_EX and control are cleared.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            A_EX      <= '0;
            B_EX      <= '0;
            D_EX      <= '0;
            CTRL_EX   <= '0;
            RW_EX     <= '0;
            VALID_EX  <= 1'b0;
            STALL_CNT <= '0;
            FWD_CNT   <= '0;
        end else if (FLUSH) begin
            CTRL_EX  <= CW_W'(pipeline_pkg::CTRL_NOP);
            RW_EX    <= '0;
            VALID_EX <= 1'b0;
        end else if (!C_Unit_MUX) begin
            CTRL_EX  <= CW_W'(pipeline_pkg::CTRL_NOP);
            RW_EX    <= '0;
            VALID_EX <= 1'b0;
            if (STALL_CNT != '1)
                STALL_CNT <= STALL_CNT + CNT_W'(1);
        end else begin
            A_EX     <= a_mux;
            B_EX     <= b_mux;
            D_EX     <= d_mux;
            CTRL_EX  <= CTRL_ID;
            RW_EX    <= RW_ID;
            VALID_EX <= 1'b1;
            if (pipeline_pkg::uses_fwd(ISA, ISB, ISD) && (FWD_CNT != '1))
                FWD_CNT <= FWD_CNT + CNT_W'(1);
        end
    end

    assign enable_LD_EX = CTRL_EX[LD_BIT] & VALID_EX;
    assign enable_RF_EX = CTRL_EX[RF_BIT] & VALID_EX;

endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
Datapath-side consumer of the hazard unit's forwarding and stall protocol. Applies the ISA/ISB/ISD operand selects to the register-file read values, and registers the result into the ID/EX pipeline register. Honours the NOP request (C_Unit_MUX low) and a branch flush by inserting a bubble. Drives RW_EX, enable_LD_EX and enable_RF_EX back to the hazard unit, closing the loop, and keeps saturating stall/forward event counters for debug.

Parameters:
DATA_W, 32, operand/result width
CW_W, 8, control word width from the control unit
LD_BIT, 0, index of the load-instruction bit in the control word
RF_BIT, 1, index of the register-file-write bit in the control word
CNT_W, 16, width of the event counters

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  synchronous reset, active-low
PA  in  DATA_W  register file port A value (RA_ID)
PB  in  DATA_W  register file port B value (RB_ID)
PD  in  DATA_W  register file port D value (RC_ID, store data)
EX_RESULT  in  DATA_W  ALU result in EX
MEM_RESULT  in  DATA_W  result in MEM
WB_RESULT  in  DATA_W  writeback value
ISA  in  2  operand A select
ISB  in  2  operand B select
ISD  in  2  store data select
C_Unit_MUX  in  1  0 = insert NOP, 1 = pass the instruction
FLUSH  in  1  branch taken, squash the instruction in ID
CTRL_ID  in  CW_W  control word of the instruction in ID
RW_ID  in  4  destination register of the instruction in ID
A_EX  out  DATA_W  registered operand A
B_EX  out  DATA_W  registered operand B
D_EX  out  DATA_W  registered store data
CTRL_EX  out  CW_W  registered control word
RW_EX  out  4  registered destination register
VALID_EX  out  1  EX holds a real instruction
enable_LD_EX  out  1  CTRL_EX[LD_BIT] & VALID_EX (combinational from registers)
enable_RF_EX  out  1  CTRL_EX[RF_BIT] & VALID_EX
STALL_CNT  out  CNT_W  bubbles inserted by the hazard request
FWD_CNT  out  CNT_W  loaded instructions that used at least one forwarded operand

Behaviour:
- Select encoding, identical for ISA, ISB and ISD:
  - 00 = register file value (PA/PB/PD)
  - 01 = EX_RESULT
  - 10 = MEM_RESULT
  - 11 = WB_RESULT
- Mux is purely combinational; the stage adds one cycle of latency from ID inputs to the *_EX outputs.
- Everything updates on the rising edge of CLK. Priority: reset > FLUSH > bubble (C_Unit_MUX=0) > load.
- Reset (RESET_N=0 at edge): all outputs 0, including the counters. enable_LD_EX and enable_RF_EX are therefore 0. Reset mid-stall discards the pending bubble state; there is no other state.
- FLUSH=1: CTRL_EX=0, RW_EX=0, VALID_EX=0. A_EX, B_EX and D_EX hold. STALL_CNT does not increment, even if C_Unit_MUX=0 in the same cycle.
- Bubble (FLUSH=0, C_Unit_MUX=0):
  - Same clears as FLUSH; A_EX, B_EX and D_EX hold.
  - STALL_CNT += 1, saturating at all-ones.
  - The stalled instruction stays in ID (held upstream), so this block sees it again next cycle.
- Load (FLUSH=0, C_Unit_MUX=1):
  - A_EX, B_EX and D_EX take the muxed values.
  - CTRL_EX=CTRL_ID, RW_EX=RW_ID, VALID_EX=1.
  - FWD_CNT += 1 (saturating) if any of ISA/ISB/ISD is nonzero.
- Counters never wrap. At max they hold until reset.
- Back-to-back loads are allowed every cycle; there is no handshake beyond C_Unit_MUX/FLUSH.
- A load followed by a dependent instruction yields exactly one bubble cycle, after which VALID_EX=0 means enable_LD_EX=0. The hazard unit then releases and forwards from MEM (10).

Decomposition:
- Shared package (pipeline_pkg):
  - select encodings SEL_RF=2'b00, SEL_EX=2'b01, SEL_MEM=2'b10, SEL_WB=2'b11
  - control-word bit indices LD_BIT and RF_BIT
  - NOP control word (all zero)
- One sub-module: fwd_mux4 (2-bit select, four DATA_W inputs), instantiated three times for A, B and D.

Test Plan:
- Reset: RESET_N=0 with all inputs nonzero -> next edge all outputs 0, including enable_LD_EX=0 and enable_RF_EX=0.
- Forward select: PA=0x11, EX_RESULT=0x22, MEM_RESULT=0x33, WB_RESULT=0x44, sweep ISA 00→11 over 4 cycles, C_Unit_MUX=1 -> A_EX is 0x11, 0x22, 0x33, 0x44 one cycle later; FWD_CNT ends at 3. Repeat for ISB/B_EX and ISD/D_EX.
- Load-use bubble: load with CTRL_ID[LD_BIT]=1, RW_ID=5, then C_Unit_MUX=0 for one cycle -> enable_LD_EX=1 after the first edge, then VALID_EX=0, CTRL_EX=0, A_EX unchanged, STALL_CNT=1.
- Flush vs bubble: FLUSH=1 and C_Unit_MUX=0 together -> VALID_EX=0 and STALL_CNT unchanged.
- Saturation: force 2^CNT_W+3 bubbles -> STALL_CNT stays 0xFFFF and does not wrap to 0.
- Reset mid-operation: RESET_N=0 while VALID_EX=1 and enable_RF_EX=1 -> next edge VALID_EX=0, enable_RF_EX=0, counters 0.
